pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 37 +++
 rtl/return_stack.sv | 70 +++++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared encodings for the program-counter sequencer: operation
//               codes, branch-condition codes, fault codes and the FSM state
//               type.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Operation encodings (op input); 101..111 are illegal
    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_BREL = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    // Branch condition encodings (cond input)
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    // Fault codes (fault_code output)
    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
    localparam logic [1:0] FC_ILLEGAL   = 2'b11;

    // Sequencer state
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } seq_state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : LIFO of return addresses. Push writes din at the current
//               occupancy and increments sp; pop decrements sp. dout always
//               shows the top entry. Push when full and pop when empty are
//               ignored. Only sp is cleared by reset, not the entries.
// Ports       : clk, reset (sync, active-low), push, pop, din -> dout (top of
//               stack), sp (occupancy), full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          din,
    output logic [ADDR_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;

    logic [SP_W-1:0]   w_sp_dec;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_sp == SP_W'(DEPTH));
    assign empty     = (r_sp == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // sp only reaches DEPTH when full, and no write happens then, so the
    // truncated write index never aliases a live entry.
    assign w_sp_dec  = r_sp - SP_W'(1);
    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_rd_idx  = w_sp_dec[IDX_W-1:0];

    assign dout      = r_mem[w_rd_idx];
    assign sp        = r_sp;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sp <= '0;
        end else if (w_push_ok) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_pop_ok) begin
            r_sp <= w_sp_dec;
        end
    end

endmodule : return_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with relative branch, absolute
//               jump, call/return via a hardware return stack, registered
//               carry/zero flags and a sticky fault state. Any fault freezes
//               all architectural state until reset.
// Ports       : clk, reset (sync, active-low), en (advance), op, cond,
//               offset (signed), target, c_in/z_in, write_c/write_z
//               -> pc, c, z, sp, stack_full, stack_empty, fault, fault_code
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int OFF_W  = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic [1:0]                 cond,
    input  logic [OFF_W-1:0]           offset,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       c_in,
    input  logic                       z_in,
    input  logic                       write_c,
    input  logic                       write_z,
    output logic [ADDR_W-1:0]          pc,
    output logic                       c,
    output logic                       z,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       fault,
    output logic [1:0]                 fault_code
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_c;
    logic              r_z;
    logic              r_fault;
    logic [1:0]        r_fault_code;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_sext;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_stack_top;
    logic              w_taken;
    logic              w_fault_now;
    logic [1:0]        w_fault_code;
    logic              w_advance;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    // Operations only take effect on an enabled edge while running.
    assign w_advance = en && (r_state == ST_RUN);

    // The stack is only touched by a CALL/RET that will not fault.
    assign w_push = w_advance && (op == OP_CALL) && !w_full;
    assign w_pop  = w_advance && (op == OP_RET) && !w_empty;

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_stack_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    // Width-cast of a signed operand sign-extends; the sum wraps naturally.
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_sext   = ADDR_W'($signed(offset));

    // Conditions look at the registered flags, never at c_in/z_in.
    always_comb begin
        w_taken = 1'b1;
        case (cond)
            COND_ALWAYS: w_taken = 1'b1;
            COND_Z:      w_taken = r_z;
            COND_C:      w_taken = r_c;
            COND_NZ:     w_taken = !r_z;
            default:     w_taken = 1'b1;
        endcase
    end

    always_comb begin
        w_next_pc    = w_pc_inc;
        w_fault_now  = 1'b0;
        w_fault_code = FC_NONE;
        case (op)
            OP_NEXT: w_next_pc = w_pc_inc;
            OP_BREL: w_next_pc = w_taken ? (w_pc_inc + w_sext) : w_pc_inc;
            OP_JUMP: w_next_pc = w_taken ? target : w_pc_inc;
            OP_CALL: begin
                if (w_full) begin
                    w_fault_now  = 1'b1;
                    w_fault_code = FC_OVERFLOW;
                end else begin
                    w_next_pc = target;
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    w_fault_now  = 1'b1;
                    w_fault_code = FC_UNDERFLOW;
                end else begin
                    w_next_pc = w_stack_top;
                end
            end
            default: begin
                w_fault_now  = 1'b1;
                w_fault_code = FC_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_pc         <= '0;
            r_c          <= 1'b0;
            r_z          <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else if (en) begin
            case (r_state)
                ST_RUN: begin
                    if (w_fault_now) begin
                        // Faulting op leaves pc and flags untouched.
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_fault_code;
                    end else begin
                        r_pc <= w_next_pc;
                        if (write_c) begin
                            r_c <= c_in;
                        end
                        if (write_z) begin
                            r_z <= z_in;
                        end
                    end
                end
                ST_FAULT: begin
                    // Sticky until reset.
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign c           = r_c;
    assign z           = r_z;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule : pc_sequencer
`default_nettype wire
